// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: grant FSM state encoding,
// full-word byte-enable pattern and timeout counter width.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IGNT = 2'd1,
    ST_DGNT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0]  BYTESEL_WORD = 4'b1111;
  localparam int unsigned TMO_W        = 8;

endpackage

// File: rtl/mem_bus_arbiter_bus_timeout_ctr.sv
// Per-transaction timeout counter.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   clear_i       hold count at zero (asserted outside a grant)
//   enable_i      count this cycle (grant cycle without completion)
//   limit_i       number of counted cycles that constitutes a timeout
//   expired_o     this enabled cycle is the limit_i-th one (combinational)
module bus_timeout_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // cnt_q holds the number of earlier stalled cycles, so the current one
  // is the limit-th when cnt_q reaches limit-1.
  assign expired_o = enable_i && (cnt_q == limit_i - W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory bus port between the instruction fetch path and
// the data path. Registered grant, data priority with anti-starvation for
// fetch, per-transaction timeout that completes with an error flag.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   i_req_i/i_addr_i                   fetch request and address
//   i_data_o/i_ready_o/i_err_o         fetch completion (ready is 1-cycle pulse)
//   d_req_i/d_addr_i/d_wr_i/
//   d_bytesel_i/d_wdata_i              data request, address, control, write data
//   d_data_o/d_ready_o/d_err_o         data completion (ready is 1-cycle pulse)
//   mem_en_o/mem_addr_o/mem_wr_o/
//   mem_bytesel_o/mem_wdata_o          bus strobe and muxed request
//   mem_data_i/mem_ready_i             bus read data and completion
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_ready_o,
  output logic              i_err_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_wr_i,
  input  logic [3:0]        d_bytesel_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_ready_o,
  output logic              d_err_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [3:0]        mem_bytesel_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ready_i
);

  localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       in_grant;
  logic       gnt_req;
  logic       tmo_en;
  logic       tmo_expired;

  assign in_grant = (state_q == ST_IGNT) || (state_q == ST_DGNT);
  assign gnt_req  = (state_q == ST_IGNT) ? i_req_i : d_req_i;
  assign tmo_en   = in_grant && gnt_req && !mem_ready_i;

  bus_timeout_ctr #(
    .W (TMO_W)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!in_grant),
    .enable_i  (tmo_en),
    .limit_i   (TMO_LIMIT),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    i_data_o      = '0;
    i_ready_o     = 1'b0;
    i_err_o       = 1'b0;
    d_data_o      = '0;
    d_ready_o     = 1'b0;
    d_err_o       = 1'b0;
    mem_en_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wr_o      = 1'b0;
    mem_bytesel_o = '0;
    mem_wdata_o   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (!i_req_i) begin
          starve_d = '0;
        end
        if (d_req_i && !(i_req_i && starve_q == STARVE_MAX)) begin
          state_d = ST_DGNT;
          if (i_req_i && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (i_req_i) begin
          state_d  = ST_IGNT;
          starve_d = '0;
        end
      end

      ST_IGNT: begin
        mem_en_o      = 1'b1;
        mem_addr_o    = i_addr_i;
        mem_bytesel_o = BYTESEL_WORD;
        // A dropped request aborts silently; a completion beats the timeout.
        if (!i_req_i) begin
          state_d = ST_DONE;
        end else if (mem_ready_i) begin
          i_ready_o = 1'b1;
          i_data_o  = mem_data_i;
          state_d   = ST_DONE;
        end else if (tmo_expired) begin
          i_ready_o = 1'b1;
          i_err_o   = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DGNT: begin
        mem_en_o      = 1'b1;
        mem_addr_o    = d_addr_i;
        mem_wr_o      = d_wr_i;
        mem_bytesel_o = d_bytesel_i;
        mem_wdata_o   = d_wdata_i;
        if (!d_req_i) begin
          state_d = ST_DONE;
        end else if (mem_ready_i) begin
          d_ready_o = 1'b1;
          d_data_o  = mem_data_i;
          state_d   = ST_DONE;
        end else if (tmo_expired) begin
          d_ready_o = 1'b1;
          d_err_o   = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A transaction cut off by reset must not report completion.
    if (rst_i) begin
      i_ready_o = 1'b0;
      i_err_o   = 1'b0;
      i_data_o  = '0;
      d_ready_o = 1'b0;
      d_err_o   = 1'b0;
      d_data_o  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
// Cycle 0 of each scenario is the IDLE cycle in which the request is first seen.
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_data_o;
  logic        i_ready_o;
  logic        i_err_o;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic        d_wr_i;
  logic [3:0]  d_bytesel_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_data_o;
  logic        d_ready_o;
  logic        d_err_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic        mem_wr_o;
  logic [3:0]  mem_bytesel_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_data_i;
  logic        mem_ready_i;

  int   tests  = 0;
  int   failed = 0;
  logic gnt;

  mem_bus_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (32),
    .STARVE_LIMIT (4),
    .TIMEOUT      (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_req_i       (i_req_i),
    .i_addr_i      (i_addr_i),
    .i_data_o      (i_data_o),
    .i_ready_o     (i_ready_o),
    .i_err_o       (i_err_o),
    .d_req_i       (d_req_i),
    .d_addr_i      (d_addr_i),
    .d_wr_i        (d_wr_i),
    .d_bytesel_i   (d_bytesel_i),
    .d_wdata_i     (d_wdata_i),
    .d_data_o      (d_data_o),
    .d_ready_o     (d_ready_o),
    .d_err_o       (d_err_o),
    .mem_en_o      (mem_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_o      (mem_wr_o),
    .mem_bytesel_o (mem_bytesel_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_data_i    (mem_data_i),
    .mem_ready_i   (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    i_req_i     = 1'b0;
    i_addr_i    = '0;
    d_req_i     = 1'b0;
    d_addr_i    = '0;
    d_wr_i      = 1'b0;
    d_bytesel_i = 4'hF;
    d_wdata_i   = '0;
    mem_data_i  = '0;
    mem_ready_i = 1'b0;

    // Reset state
    step; step;
    #1;
    chkb("rst_en",      mem_en_o, 1'b0);
    chkw("rst_addr",    mem_addr_o, 32'h0);
    chkb("rst_d_ready", d_ready_o, 1'b0);
    chkb("rst_i_ready", i_ready_o, 1'b0);
    chkw("rst_bytesel", 32'(mem_bytesel_o), 32'h0);
    rst_i = 1'b0;
    step;

    // 1: data read, completion in second grant cycle
    step; d_req_i = 1'b1; d_addr_i = 32'h0000_1000; d_wr_i = 1'b0; d_bytesel_i = 4'hF;
    #1 chkb("t1_c0_en", mem_en_o, 1'b0);
    step;
    #1 chkb("t1_c1_en", mem_en_o, 1'b1);
    chkw("t1_c1_addr", mem_addr_o, 32'h0000_1000);
    chkb("t1_c1_rdy", d_ready_o, 1'b0);
    chkw("t1_c1_data", d_data_o, 32'h0);
    step; mem_ready_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    #1 chkb("t1_c2_en", mem_en_o, 1'b1);
    chkb("t1_c2_rdy", d_ready_o, 1'b1);
    chkw("t1_c2_data", d_data_o, 32'hDEAD_BEEF);
    chkb("t1_c2_err", d_err_o, 1'b0);
    chkb("t1_c2_irdy", i_ready_o, 1'b0);
    step; d_req_i = 1'b0; mem_ready_i = 1'b0;
    #1 chkb("t1_c3_en", mem_en_o, 1'b0);
    chkb("t1_c3_rdy", d_ready_o, 1'b0);
    chkw("t1_c3_data", d_data_o, 32'h0);
    step; step;

    // 2: both requesting, immediate completions: D at 1,4,7,10 then I at 13
    step; i_req_i = 1'b1; d_req_i = 1'b1; i_addr_i = 32'h0000_4000;
    d_addr_i = 32'h0000_5000; d_wr_i = 1'b1; d_wdata_i = 32'hFFFF_FFFF;
    #1 chkb("t2_c0_en", mem_en_o, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      step;
      gnt         = (c % 3 == 1);
      mem_ready_i = gnt;
      mem_data_i  = 32'hA000_0000 | 32'(c);
      #1;
      chkb($sformatf("t2_c%0d_en", c), mem_en_o, gnt);
      chkb($sformatf("t2_c%0d_drdy", c), d_ready_o, gnt && (c < 13));
      chkb($sformatf("t2_c%0d_irdy", c), i_ready_o, gnt && (c == 13));
      if (c == 13) begin
        chkw("t2_c13_addr", mem_addr_o, 32'h0000_4000);
        chkw("t2_c13_bytesel", 32'(mem_bytesel_o), 32'hF);
        chkb("t2_c13_wr", mem_wr_o, 1'b0);
        chkw("t2_c13_wdata", mem_wdata_o, 32'h0);
        chkw("t2_c13_idata", i_data_o, 32'hA000_000D);
      end
    end
    step; i_req_i = 1'b0; d_req_i = 1'b0; mem_ready_i = 1'b0;
    #1 chkb("t2_c14_en", mem_en_o, 1'b0);
    step; step;

    // 3: fetch timeout after 8 grant cycles, then bus free again
    d_wr_i = 1'b0; d_wdata_i = '0;
    step; i_req_i = 1'b1; i_addr_i = 32'h0000_6000; mem_data_i = 32'h1234_5678;
    #1 chkb("t3_c0_en", mem_en_o, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      step;
      #1;
      chkb($sformatf("t3_c%0d_en", c), mem_en_o, 1'b1);
      chkb($sformatf("t3_c%0d_rdy", c), i_ready_o, 1'b0);
    end
    step;
    #1 chkb("t3_c8_en", mem_en_o, 1'b1);
    chkb("t3_c8_rdy", i_ready_o, 1'b1);
    chkb("t3_c8_err", i_err_o, 1'b1);
    chkw("t3_c8_data", i_data_o, 32'h0);
    step; i_req_i = 1'b0; mem_ready_i = 1'b1;
    #1 chkb("t3_c9_en", mem_en_o, 1'b0);
    chkb("t3_c9_rdy", i_ready_o, 1'b0);
    chkb("t3_c9_err", i_err_o, 1'b0);
    step; d_req_i = 1'b1; d_addr_i = 32'h0000_7000;
    #1 chkb("t3_c10_en", mem_en_o, 1'b0);
    chkb("t3_c10_drdy", d_ready_o, 1'b0);
    step;
    #1 chkb("t3_c11_en", mem_en_o, 1'b1);
    chkb("t3_c11_drdy", d_ready_o, 1'b1);
    step; d_req_i = 1'b0; mem_ready_i = 1'b0;
    #1 chkb("t3_c12_en", mem_en_o, 1'b0);
    step; step;

    // 4: data write with partial byte enables held for the whole grant
    step; d_req_i = 1'b1; d_addr_i = 32'h0000_8000; d_wr_i = 1'b1;
    d_bytesel_i = 4'b0011; d_wdata_i = 32'hCAFE_F00D;
    #1 chkb("t4_c0_en", mem_en_o, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step;
      mem_ready_i = (c == 3);
      #1;
      chkb($sformatf("t4_c%0d_en", c), mem_en_o, 1'b1);
      chkb($sformatf("t4_c%0d_wr", c), mem_wr_o, 1'b1);
      chkw($sformatf("t4_c%0d_bytesel", c), 32'(mem_bytesel_o), 32'h3);
      chkw($sformatf("t4_c%0d_wdata", c), mem_wdata_o, 32'hCAFE_F00D);
      chkw($sformatf("t4_c%0d_addr", c), mem_addr_o, 32'h0000_8000);
      chkb($sformatf("t4_c%0d_rdy", c), d_ready_o, c == 3);
    end
    step; d_req_i = 1'b0; mem_ready_i = 1'b0;
    #1 chkb("t4_c4_en", mem_en_o, 1'b0);
    chkb("t4_c4_wr", mem_wr_o, 1'b0);
    chkw("t4_c4_bytesel", 32'(mem_bytesel_o), 32'h0);
    chkw("t4_c4_wdata", mem_wdata_o, 32'h0);
    step; step;

    // 5: reset in second grant cycle drops the transaction, request regranted
    step; d_req_i = 1'b1; d_wr_i = 1'b0; d_addr_i = 32'h0000_9000; d_bytesel_i = 4'hF;
    d_wdata_i = '0;
    #1 chkb("t5_c0_en", mem_en_o, 1'b0);
    step;
    #1 chkb("t5_c1_en", mem_en_o, 1'b1);
    step; rst_i = 1'b1; mem_ready_i = 1'b1; mem_data_i = 32'h5555_AAAA;
    #1 chkb("t5_c2_rdy", d_ready_o, 1'b0);
    chkw("t5_c2_data", d_data_o, 32'h0);
    chkb("t5_c2_err", d_err_o, 1'b0);
    step; rst_i = 1'b0; mem_ready_i = 1'b0;
    #1 chkb("t5_c3_en", mem_en_o, 1'b0);
    chkw("t5_c3_addr", mem_addr_o, 32'h0);
    chkb("t5_c3_rdy", d_ready_o, 1'b0);
    chkw("t5_c3_bytesel", 32'(mem_bytesel_o), 32'h0);
    step;
    #1 chkb("t5_c4_en", mem_en_o, 1'b1);
    chkw("t5_c4_addr", mem_addr_o, 32'h0000_9000);
    step; mem_ready_i = 1'b1;
    #1 chkb("t5_c5_rdy", d_ready_o, 1'b1);
    chkw("t5_c5_data", d_data_o, 32'h5555_AAAA);
    step; d_req_i = 1'b0; mem_ready_i = 1'b0;
    #1 chkb("t5_c6_en", mem_en_o, 1'b0);
    step; step;

    // 6: completion on the timeout-limit cycle wins over the error
    step; i_req_i = 1'b1; i_addr_i = 32'h0000_A000;
    #1 chkb("t6_c0_en", mem_en_o, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      step;
      #1 chkb($sformatf("t6_c%0d_rdy", c), i_ready_o, 1'b0);
    end
    step; mem_ready_i = 1'b1; mem_data_i = 32'h0BAD_F00D;
    #1 chkb("t6_c8_rdy", i_ready_o, 1'b1);
    chkb("t6_c8_err", i_err_o, 1'b0);
    chkw("t6_c8_data", i_data_o, 32'h0BAD_F00D);
    step; i_req_i = 1'b0; mem_ready_i = 1'b0;
    #1 chkb("t6_c9_en", mem_en_o, 1'b0);
    step; step;

    // 7: requester drops mid-grant: no ready, strobe falls
    step; d_req_i = 1'b1; d_addr_i = 32'h0000_B000;
    step;
    #1 chkb("t7_c1_en", mem_en_o, 1'b1);
    step; d_req_i = 1'b0; mem_ready_i = 1'b1;
    #1 chkb("t7_c2_rdy", d_ready_o, 1'b0);
    step; mem_ready_i = 1'b0;
    #1 chkb("t7_c3_en", mem_en_o, 1'b0);
    step;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
